// File: rtl/mfa_pkg.sv
// -----------------------------------------------------------------------------
// mfa_pkg
// Shared definitions for the multifractal moment accumulator:
//   - FSM state encoding (IDLE / ACCUM / EMIT)
//   - default geometry (grid side exponent, level count, mass width)
//   - accumulator width constants at the default geometry, plus width
//     functions so parameterised modules can size themselves consistently
// -----------------------------------------------------------------------------
package mfa_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_EMIT  = 2'd2
   } mfa_state_e;

   localparam int PKG_BOX_IDX  = 3;
   localparam int PKG_MAX_BOX  = 3;
   localparam int PKG_DATA_LEN = 8;

   // Box count up to 4^BOX_IDX inclusive needs 2*BOX_IDX+1 bits.
   function automatic int cnt_width(input int box_idx);
      return 2 * box_idx + 1;
   endfunction

   // 4^BOX_IDX masses of DATA_LEN bits each cannot carry past this width.
   function automatic int sum_width(input int box_idx, input int data_len);
      return data_len + 2 * box_idx;
   endfunction

   // Squares are 2*DATA_LEN bits; summing 4^BOX_IDX of them adds 2*BOX_IDX.
   function automatic int sq_width(input int box_idx, input int data_len);
      return 2 * data_len + 2 * box_idx;
   endfunction

   localparam int CNT_W = cnt_width(PKG_BOX_IDX);
   localparam int SUM_W = sum_width(PKG_BOX_IDX, PKG_DATA_LEN);
   localparam int SQ_W  = sq_width(PKG_BOX_IDX, PKG_DATA_LEN);

endpackage

// File: rtl/mfa_moment_datapath.sv
// -----------------------------------------------------------------------------
// mfa_moment_datapath
// Accumulates the per-level statistics of a stream of box masses.
//   CLK, RST   clock / asynchronous active-high reset
//   clr        synchronous clear of all accumulators (level open or soft clear)
//   acc_en     fold in_data into the statistics this cycle
//   in_data    box mass
//   count      number of nonzero masses seen
//   sum        sum of masses
//   sumsq      sum of squared masses
//   peak       largest mass seen
// Widths are chosen so a full level of full-scale masses never overflows.
// -----------------------------------------------------------------------------
module mfa_moment_datapath
   import mfa_pkg::*;
#(
   parameter int BOX_IDX  = PKG_BOX_IDX,
   parameter int DATA_LEN = PKG_DATA_LEN
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            clr,
   input  logic                            acc_en,
   input  logic [DATA_LEN-1:0]             in_data,
   output logic [2*BOX_IDX:0]              count,
   output logic [DATA_LEN+2*BOX_IDX-1:0]   sum,
   output logic [2*DATA_LEN+2*BOX_IDX-1:0] sumsq,
   output logic [DATA_LEN-1:0]             peak
);

   localparam int CW = cnt_width(BOX_IDX);
   localparam int SW = sum_width(BOX_IDX, DATA_LEN);
   localparam int QW = sq_width(BOX_IDX, DATA_LEN);

   logic [QW-1:0] sq_s;
   logic          nonzero_s;

   // Square and occupancy of the incoming mass (zero-extended before multiply).
   always_comb begin
      sq_s      = QW'(in_data) * QW'(in_data);
      nonzero_s = (in_data != {DATA_LEN{1'b0}});
   end

   // Statistics registers; clear has priority over accumulation.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count <= {CW{1'b0}};
         sum   <= {SW{1'b0}};
         sumsq <= {QW{1'b0}};
         peak  <= {DATA_LEN{1'b0}};
      end else if (clr) begin
         count <= {CW{1'b0}};
         sum   <= {SW{1'b0}};
         sumsq <= {QW{1'b0}};
         peak  <= {DATA_LEN{1'b0}};
      end else if (acc_en) begin
         count <= count + CW'(nonzero_s);
         sum   <= sum + SW'(in_data);
         sumsq <= sumsq + sq_s;
         if (in_data > peak) begin
            peak <= in_data;
         end
      end
   end

endmodule

// File: rtl/mfa_moment_acc.sv
// -----------------------------------------------------------------------------
// mfa_moment_acc
// Collects the coarse box masses of one grouping level and emits one record
// (occupied-box count, total mass, second moment, peak mass) per level over
// a valid/ready handshake.
//   CLK, RST     clock / asynchronous active-high reset
//   BC_mode      synchronous clear, same effect as RST
//   level_start  pulse opening a level; level_boxes sampled with it
//   in_valid     box mass valid, in_data box mass
//   out_ready    downstream accepts the record
//   out_valid    record valid; out_level/out_count/out_sum/out_sumsq/out_max
//                hold the record (and keep it after transfer until a new level)
//   busy         a level is being accumulated or emitted
//   drop_err     sticky: a sample or level_start arrived when it could not be
//                used; cleared only by RST / BC_mode
// -----------------------------------------------------------------------------
module mfa_moment_acc
   import mfa_pkg::*;
#(
   parameter int BOX_IDX  = PKG_BOX_IDX,
   parameter int MAX_BOX  = PKG_MAX_BOX,
   parameter int DATA_LEN = PKG_DATA_LEN
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            BC_mode,
   input  logic                            level_start,
   input  logic [2*BOX_IDX:0]              level_boxes,
   input  logic                            in_valid,
   input  logic [DATA_LEN-1:0]             in_data,
   input  logic                            out_ready,
   output logic                            out_valid,
   output logic [BOX_IDX-1:0]              out_level,
   output logic [2*BOX_IDX:0]              out_count,
   output logic [DATA_LEN+2*BOX_IDX-1:0]   out_sum,
   output logic [2*DATA_LEN+2*BOX_IDX-1:0] out_sumsq,
   output logic [DATA_LEN-1:0]             out_max,
   output logic                            busy,
   output logic                            drop_err
);

   localparam int CW = cnt_width(BOX_IDX);
   localparam logic [BOX_IDX-1:0] LAST_LEVEL = BOX_IDX'(MAX_BOX - 1);

   mfa_state_e        state_r;
   mfa_state_e        state_next_s;
   logic [CW-1:0]     target_r;
   logic [CW-1:0]     seen_r;
   logic [CW-1:0]     seen_inc_s;
   logic [BOX_IDX-1:0] level_r;
   logic              out_valid_r;
   logic              busy_r;
   logic              drop_err_r;
   logic              load_s;
   logic              acc_en_s;
   logic              drop_set_s;
   logic              xfer_s;
   logic              zero_level_s;
   logic              acc_clr_s;

   // Next-state and control decode; level_start always wins over other events.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      acc_en_s     = 1'b0;
      drop_set_s   = 1'b0;
      xfer_s       = 1'b0;
      seen_inc_s   = seen_r + CW'(1);
      zero_level_s = (level_boxes == {CW{1'b0}});
      case (state_r)
         ST_IDLE: begin
            drop_set_s = in_valid;
            if (level_start) begin
               load_s       = 1'b1;
               // An empty level has nothing to wait for: emit the zero record.
               state_next_s = zero_level_s ? ST_EMIT : ST_ACCUM;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (level_start) begin
               // Abandon the pending level and reload for the new one.
               drop_set_s   = 1'b1;
               load_s       = 1'b1;
               state_next_s = zero_level_s ? ST_EMIT : ST_ACCUM;
            end else if (in_valid) begin
               acc_en_s     = 1'b1;
               state_next_s = (seen_inc_s == target_r) ? ST_EMIT : ST_ACCUM;
            end else begin
               state_next_s = ST_ACCUM;
            end
         end
         ST_EMIT: begin
            drop_set_s = in_valid | level_start;
            // out_valid is high throughout EMIT, so ready alone completes it.
            xfer_s     = out_ready;
            if (level_start) begin
               load_s       = 1'b1;
               state_next_s = zero_level_s ? ST_EMIT : ST_ACCUM;
            end else if (out_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_EMIT;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
      acc_clr_s = load_s | BC_mode;
   end

   // FSM state, level bookkeeping and registered status outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r     <= ST_IDLE;
         target_r    <= {CW{1'b0}};
         seen_r      <= {CW{1'b0}};
         level_r     <= {BOX_IDX{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         drop_err_r  <= 1'b0;
      end else if (BC_mode) begin
         state_r     <= ST_IDLE;
         target_r    <= {CW{1'b0}};
         seen_r      <= {CW{1'b0}};
         level_r     <= {BOX_IDX{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         drop_err_r  <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         out_valid_r <= (state_next_s == ST_EMIT);
         busy_r      <= (state_next_s != ST_IDLE);
         if (load_s) begin
            target_r <= level_boxes;
            seen_r   <= {CW{1'b0}};
         end else if (acc_en_s) begin
            seen_r <= seen_inc_s;
         end
         if (xfer_s) begin
            level_r <= (level_r == LAST_LEVEL) ? {BOX_IDX{1'b0}} : level_r + BOX_IDX'(1);
         end
         if (drop_set_s) begin
            drop_err_r <= 1'b1;
         end
      end
   end

   mfa_moment_datapath #(
      .BOX_IDX  (BOX_IDX),
      .DATA_LEN (DATA_LEN)
   ) u_datapath (
      .CLK     (CLK),
      .RST     (RST),
      .clr     (acc_clr_s),
      .acc_en  (acc_en_s),
      .in_data (in_data),
      .count   (out_count),
      .sum     (out_sum),
      .sumsq   (out_sumsq),
      .peak    (out_max)
   );

   assign out_valid = out_valid_r;
   assign out_level = level_r;
   assign busy      = busy_r;
   assign drop_err  = drop_err_r;

endmodule

// File: tb/tb_mfa_moment_acc.sv
// -----------------------------------------------------------------------------
// tb_mfa_moment_acc
// Directed self-checking bench for mfa_moment_acc (default geometry:
// BOX_IDX=3, MAX_BOX=3, DATA_LEN=8). Expected records are computed from the
// stimulus and queued when a level is driven, then popped when the DUT
// presents a record.
// -----------------------------------------------------------------------------
module tb_mfa_moment_acc;
   import mfa_pkg::*;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             BC_mode = 1'b0;
   logic             level_start = 1'b0;
   logic [CNT_W-1:0] level_boxes = '0;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data = 8'd0;
   logic             out_ready = 1'b0;
   logic             out_valid;
   logic [2:0]       out_level;
   logic [CNT_W-1:0] out_count;
   logic [SUM_W-1:0] out_sum;
   logic [SQ_W-1:0]  out_sumsq;
   logic [7:0]       out_max;
   logic             busy;
   logic             drop_err;

   typedef struct {
      int level;
      int count;
      int sum;
      int sumsq;
      int max;
   } rec_t;

   rec_t exp_q[$];
   int   stim[$];
   int   exp_level = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   mfa_moment_acc dut (
      .CLK         (CLK),
      .RST         (RST),
      .BC_mode     (BC_mode),
      .level_start (level_start),
      .level_boxes (level_boxes),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_level   (out_level),
      .out_count   (out_count),
      .out_sum     (out_sum),
      .out_sumsq   (out_sumsq),
      .out_max     (out_max),
      .busy        (busy),
      .drop_err    (drop_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference statistics of the samples currently in stim.
   function automatic rec_t model(input int lvl);
      rec_t r;
      r.level = lvl; r.count = 0; r.sum = 0; r.sumsq = 0; r.max = 0;
      foreach (stim[i]) begin
         if (stim[i] != 0) r.count++;
         r.sum   += stim[i];
         r.sumsq += stim[i] * stim[i];
         if (stim[i] > r.max) r.max = stim[i];
      end
      return r;
   endfunction

   // Open a level and stream the samples in stim back-to-back.
   task automatic send_level(input int boxes, input bit push);
      if (push) exp_q.push_back(model(exp_level));
      level_start = 1'b1;
      level_boxes = CNT_W'(boxes);
      @(posedge CLK); #1;
      level_start = 1'b0;
      foreach (stim[i]) begin
         in_valid = 1'b1;
         in_data  = 8'(stim[i]);
         @(posedge CLK); #1;
      end
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for a record, compare it with the scoreboard, transfer it.
   task automatic collect(input int budget);
      rec_t e;
      int   i = 1;
      @(negedge CLK);
      while (!out_valid && i < budget) begin
         @(negedge CLK);
         i++;
      end
      check("rec_valid", 32'(out_valid), 32'd1);
      check("rec_pending", 32'(exp_q.size() != 0), 32'd1);
      if (out_valid && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("rec_level", 32'(out_level), e.level);
         check("rec_count", 32'(out_count), e.count);
         check("rec_sum",   32'(out_sum),   e.sum);
         check("rec_sumsq", 32'(out_sumsq), e.sumsq);
         check("rec_max",   32'(out_max),   e.max);
         out_ready = 1'b1;
         @(posedge CLK); #1;
         exp_level = (exp_level + 1) % 3;
      end
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_drop",  32'(drop_err),  32'd0);
      check("rst_sum",   32'(out_sum),   32'd0);
      check("rst_level", 32'(out_level), 32'd0);
      RST = 1'b0;
      @(posedge CLK); #1;

      // Basic level: 3,0,5,2 with ready high; record exactly one cycle later
      out_ready = 1'b1;
      stim = '{3, 0, 5, 2};
      send_level(4, 1'b1);
      check("basic_busy", 32'(busy), 32'd1);
      collect(1);
      @(negedge CLK);
      check("basic_valid_drop", 32'(out_valid), 32'd0);
      check("basic_idle",       32'(busy),      32'd0);
      check("basic_hold_sum",   32'(out_sum),   32'd10);
      check("basic_drop",       32'(drop_err),  32'd0);

      // Full-scale level of 16 boxes
      stim = {};
      for (int i = 0; i < 16; i++) stim.push_back(255);
      send_level(16, 1'b1);
      collect(1);

      // Stall in EMIT for 5 cycles with stray samples
      out_ready = 1'b0;
      stim = '{1, 2, 3};
      send_level(3, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_sum",   32'(out_sum),   32'd6);
         check("stall_max",   32'(out_max),   32'd3);
         check("stall_count", 32'(out_count), 32'd3);
         in_valid = (k == 1 || k == 2);
         in_data  = 8'd200;
      end
      in_valid = 1'b0;
      @(negedge CLK);
      check("stall_drop", 32'(drop_err), 32'd1);
      collect(1);

      // Fourth level wraps the level index back to 0
      stim = '{9};
      send_level(1, 1'b1);
      collect(1);

      // Soft clear in IDLE clears the sticky error and the level index
      BC_mode = 1'b1;
      @(posedge CLK); #1;
      BC_mode = 1'b0;
      exp_level = 0;
      @(negedge CLK);
      check("bc_drop_clr", 32'(drop_err), 32'd0);

      // Level 0, then an abandoned level replaced mid-way (index stays 1)
      stim = '{4, 4};
      send_level(2, 1'b1);
      collect(1);
      stim = '{50, 60};
      send_level(4, 1'b0);
      stim = '{7, 7, 0, 1};
      send_level(4, 1'b1);
      collect(1);
      check("abandon_drop", 32'(drop_err), 32'd1);
      check("abandon_one_rec", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset mid-ACCUM, off the clock edge
      stim = '{10, 20};
      send_level(4, 1'b0);
      check("pre_rst_busy", 32'(busy),    32'd1);
      check("pre_rst_sum",  32'(out_sum), 32'd30);
      #3 RST = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_busy",  32'(busy),      32'd0);
      check("arst_sum",   32'(out_sum),   32'd0);
      check("arst_sumsq", 32'(out_sumsq), 32'd0);
      check("arst_drop",  32'(drop_err),  32'd0);
      #2 RST = 1'b0;
      exp_level = 0;
      @(posedge CLK); #1;

      // Soft clear while a record is waiting in EMIT
      out_ready = 1'b0;
      stim = '{5};
      send_level(1, 1'b0);
      @(negedge CLK);
      check("bce_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      in_data  = 8'd9;
      @(negedge CLK);
      in_valid = 1'b0;
      check("bce_drop_set", 32'(drop_err), 32'd1);
      check("bce_rec_kept", 32'(out_sum),  32'd5);
      BC_mode = 1'b1;
      @(posedge CLK); #1;
      BC_mode = 1'b0;
      @(negedge CLK);
      check("bce_valid_clr", 32'(out_valid), 32'd0);
      check("bce_busy_clr",  32'(busy),      32'd0);
      check("bce_drop_clr",  32'(drop_err),  32'd0);
      check("bce_sum_clr",   32'(out_sum),   32'd0);

      // Empty level goes straight to EMIT with an all-zero record
      out_ready = 1'b1;
      stim = {};
      send_level(0, 1'b1);
      collect(1);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
